mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- MEM stage plus MEM/WB pipeline register of the MIPS pipeline.
- Consumes the EX/MEM register outputs (address, store data, destination register, control bits).
- Runs the data-memory access over a req/ack bus and stalls the upstream pipeline while the access is outstanding.
- Registers the results for writeback.

Parameters:
- DATA_W, 32, data and address width in bits.
- REG_W, 5, register-file index width.
- ACK_TIMEOUT, 16, maximum cycles in REQ before abort; used only with MEM_TIMEOUT_EN.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- Address  input  DATA_W  ALU result / memory address from EX/MEM.
- Write_Data  input  DATA_W  store data from EX/MEM.
- regdst  input  REG_W  destination register from EX/MEM.
- RegWrite_i  input  1  register-write control.
- Mem_Read  input  1  load request.
- Mem_Write  input  1  store request.
- MemtoReg_i  input  1  writeback-select control.
- stall  output  1  holds EX/MEM and all earlier stages when high.
- dmem_req  output  1  memory request, registered.
- dmem_we  output  1  1 = write, 0 = read; valid while dmem_req is high.
- dmem_addr  output  DATA_W  equals Address while dmem_req is high.
- dmem_wdata  output  DATA_W  equals Write_Data while dmem_req is high.
- dmem_rdata  input  DATA_W  read data; valid when dmem_ack is high.
- dmem_ack  input  1  one-cycle completion pulse.
- wb_read_data  output  DATA_W  load data for writeback.
- wb_alu_result  output  DATA_W  registered Address.
- wb_regdst  output  REG_W  registered destination.
- wb_reg_write  output  1  registered RegWrite.
- wb_mem_to_reg  output  1  registered MemtoReg.
- bus_err  output  1  sticky timeout flag; constant 0 without MEM_TIMEOUT_EN.

Behaviour:
- Clocking and reset: single clock. Reset is synchronous and active-high on rst.
- Reset values: state IDLE, dmem_req=0, dmem_we=0, all wb_* outputs 0, bus_err=0, timeout counter 0.
- Reset mid-access: the request is dropped the next edge, with no MEM/WB capture.
- memop = Mem_Read | Mem_Write. If both are high, the access is treated as a write.

State machine, two states:
- IDLE, memop=0:
  - stall=0.
  - MEM/WB captures inputs at the edge; wb_read_data <= 0.
  - Latency 1 cycle.
- IDLE, memop=1:
  - stall=1 (combinational).
  - MEM/WB loads a bubble: wb_reg_write=0, wb_mem_to_reg=0, other wb_* fields hold.
  - Next state REQ; dmem_req <= 1, dmem_we <= Mem_Write.
- REQ:
  - Upstream inputs are stable because of the stall.
  - stall = ~dmem_ack.
  - Without ack: bubble into MEM/WB, stay in REQ.
  - On ack: MEM/WB captures inputs; wb_read_data <= dmem_rdata for reads, 0 for writes. dmem_req <= 0, state <= IDLE.

Timing:
- Minimum memop latency is 2 cycles (ack in the first REQ cycle).
- Back-to-back memops each re-enter via IDLE, so dmem_req drops for at least 1 cycle between accesses.
- dmem_ack while in IDLE is ignored.
- No arithmetic on data. Address passes through unmodified; word alignment is the memory's concern.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- With the macro:
  - An 8-bit counter clears on entry to REQ and increments each REQ cycle without ack.
  - When the counter reaches ACK_TIMEOUT-1 with no ack: dmem_req <= 0, state <= IDLE, bus_err <= 1 (sticky until rst), MEM/WB captures the instruction as a bubble (wb_reg_write=0), stall=0 that cycle.
  - An ack arriving in the same cycle as the timeout wins: normal completion, no error.
- Without the macro: no counter, REQ waits indefinitely, bus_err tied 0.

Decomposition:
- Shared package mips_pkg holds:
  - The mem_state_t enum {IDLE, REQ}.
  - Width constants DATA_W and REG_W.
  - The default ACK_TIMEOUT constant.
- One natural sub-module, dmem_access_fsm, owns:
  - The state register, timeout counter, dmem_req/dmem_we, stall and capture-enable generation.
- mem_wb_stage keeps the MEM/WB register and the data muxing.

Test Plan:
- ALU op (Address=0x10, regdst=5, RegWrite_i=1, no memop) -> next edge: wb_alu_result=0x10, wb_regdst=5, wb_reg_write=1, stall never high.
- Load with Address=0x40 and 3-cycle ack delay, dmem_rdata=0xDEADBEEF -> stall high for 4 cycles; dmem_req=1 with dmem_addr=0x40 and dmem_we=0; then wb_read_data=0xDEADBEEF, wb_mem_to_reg=1; bubbles (wb_reg_write=0) during the stall.
- Store with Address=0x80, Write_Data=0x1234, immediate ack -> dmem_we=1, dmem_wdata=0x1234 for 1 cycle, stall for 1 cycle only, wb_read_data=0.
- Back-to-back loads to 0x0 and 0x4 -> two separate dmem_req pulses separated by 1 low cycle, both results reach MEM/WB in order.
- rst asserted during REQ -> next edge: dmem_req=0, state IDLE, all wb_* 0, and a late dmem_ack is ignored.
- MEM_TIMEOUT_EN defined, ACK_TIMEOUT=4, no ack -> abort after 4 REQ cycles, bus_err=1 and stays 1, wb_reg_write=0, pipeline resumes.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and default constants for the MIPS MEM/WB slice.
// Contents: mem_state_t (data-memory access state), the default data/address
// width, the default register-index width and the default ack timeout.
package mips_pkg;

  localparam int DATA_W      = 32;
  localparam int REG_W       = 5;
  localparam int ACK_TIMEOUT = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } mem_state_t;

endpackage

// File: rtl/dmem_access_fsm.sv
// Data-memory access sequencer for the MEM stage.
// Owns the access state, the registered req/we bus controls, the upstream
// stall and the MEM/WB load enable.
// Optional feature (macro MEM_TIMEOUT_EN): an ack timeout that aborts the
// access and raises a sticky bus_err. Without the macro, REQ waits for ack
// with no time limit and bus_err is tied low.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   mem_read, mem_write memory-op controls from EX/MEM
//   dmem_ack            one-cycle completion pulse from memory
//   stall               holds EX/MEM and earlier stages
//   dmem_req, dmem_we   registered bus request / write select
//   wb_load             1: MEM/WB captures the instruction, 0: bubble
//   load_rdata          with wb_load, take dmem_rdata as the load result
//   bus_err             sticky timeout flag
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no access outstanding; a memop here stalls and launches REQ
// REQ   | dmem_req high, waiting for dmem_ack (or the timeout)
module dmem_access_fsm
`ifdef MEM_TIMEOUT_EN
  #(parameter int ACK_TIMEOUT = mips_pkg::ACK_TIMEOUT)
`endif
(
  input  logic clk,
  input  logic rst,
  input  logic mem_read,
  input  logic mem_write,
  input  logic dmem_ack,
  output logic stall,
  output logic dmem_req,
  output logic dmem_we,
  output logic wb_load,
  output logic load_rdata,
  output logic bus_err
);
  import mips_pkg::*;

  mem_state_t state_q, state_d;
  logic       req_q, req_d;
  logic       we_q, we_d;
  logic       memop;

  assign memop = mem_read | mem_write;

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

  logic [7:0] tmo_cnt_q, tmo_cnt_d;
  logic       err_q, err_d;
  logic       tmo_hit;

  assign tmo_hit = (tmo_cnt_q == TMO_LAST);
`endif

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    stall      = 1'b0;
    wb_load    = 1'b0;
    load_rdata = 1'b0;
`ifdef MEM_TIMEOUT_EN
    tmo_cnt_d  = tmo_cnt_q;
    err_d      = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (memop) begin
          stall   = 1'b1;
          state_d = REQ;
          req_d   = 1'b1;
          // a simultaneous read+write is issued as a write
          we_d    = mem_write;
`ifdef MEM_TIMEOUT_EN
          tmo_cnt_d = 8'd0;
`endif
        end else begin
          wb_load = 1'b1;
        end
      end
      REQ: begin
        if (dmem_ack) begin
          wb_load    = 1'b1;
          load_rdata = ~we_q;
          state_d    = IDLE;
          req_d      = 1'b0;
          we_d       = 1'b0;
`ifdef MEM_TIMEOUT_EN
        end else if (tmo_hit) begin
          // abort: instruction retires as a bubble, pipeline released
          state_d = IDLE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          err_d   = 1'b1;
`endif
        end else begin
          stall = 1'b1;
`ifdef MEM_TIMEOUT_EN
          tmo_cnt_d = tmo_cnt_q + 8'd1;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= 8'd0;
      err_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      err_q     <= err_d;
    end
  end

  assign bus_err = err_q;
`else
  assign bus_err = 1'b0;
`endif

  assign dmem_req = req_q;
  assign dmem_we  = we_q;

endmodule

// File: rtl/mem_wb_stage.sv
// MIPS MEM stage plus MEM/WB pipeline register.
// Runs the data-memory access through dmem_access_fsm and registers the
// writeback fields. While an access is outstanding the register takes
// bubbles (reg_write/mem_to_reg cleared, other fields held).
// Optional feature (macro MEM_TIMEOUT_EN): ack timeout with sticky bus_err.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   Address, Write_Data, regdst  EX/MEM data fields
//   RegWrite_i, Mem_Read, Mem_Write, MemtoReg_i  EX/MEM controls
//   stall                        holds EX/MEM and earlier stages
//   dmem_*                       req/ack data-memory bus
//   wb_*                         MEM/WB register outputs
//   bus_err                      sticky timeout flag
module mem_wb_stage #(
  parameter int DATA_W      = mips_pkg::DATA_W,
  parameter int REG_W       = mips_pkg::REG_W,
  parameter int ACK_TIMEOUT = mips_pkg::ACK_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] Address,
  input  logic [DATA_W-1:0] Write_Data,
  input  logic [REG_W-1:0]  regdst,
  input  logic              RegWrite_i,
  input  logic              Mem_Read,
  input  logic              Mem_Write,
  input  logic              MemtoReg_i,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic [DATA_W-1:0] wb_read_data,
  output logic [DATA_W-1:0] wb_alu_result,
  output logic [REG_W-1:0]  wb_regdst,
  output logic              wb_reg_write,
  output logic              wb_mem_to_reg,
  output logic              bus_err
);
  import mips_pkg::*;

  logic wb_load;
  logic load_rdata;

  dmem_access_fsm
`ifdef MEM_TIMEOUT_EN
    #(.ACK_TIMEOUT(ACK_TIMEOUT))
`endif
  u_fsm (
    .clk        (clk),
    .rst        (rst),
    .mem_read   (Mem_Read),
    .mem_write  (Mem_Write),
    .dmem_ack   (dmem_ack),
    .stall      (stall),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .wb_load    (wb_load),
    .load_rdata (load_rdata),
    .bus_err    (bus_err)
  );

  // EX/MEM is frozen by stall, so the bus can be driven straight from it.
  assign dmem_addr  = Address;
  assign dmem_wdata = Write_Data;

  logic [DATA_W-1:0] wb_read_data_q, wb_read_data_d;
  logic [DATA_W-1:0] wb_alu_result_q, wb_alu_result_d;
  logic [REG_W-1:0]  wb_regdst_q, wb_regdst_d;
  logic              wb_reg_write_q, wb_reg_write_d;
  logic              wb_mem_to_reg_q, wb_mem_to_reg_d;

  always_comb begin
    wb_read_data_d  = wb_read_data_q;
    wb_alu_result_d = wb_alu_result_q;
    wb_regdst_d     = wb_regdst_q;
    wb_reg_write_d  = 1'b0;
    wb_mem_to_reg_d = 1'b0;
    if (wb_load) begin
      wb_read_data_d  = load_rdata ? dmem_rdata : '0;
      wb_alu_result_d = Address;
      wb_regdst_d     = regdst;
      wb_reg_write_d  = RegWrite_i;
      wb_mem_to_reg_d = MemtoReg_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_read_data_q  <= '0;
      wb_alu_result_q <= '0;
      wb_regdst_q     <= '0;
      wb_reg_write_q  <= 1'b0;
      wb_mem_to_reg_q <= 1'b0;
    end else begin
      wb_read_data_q  <= wb_read_data_d;
      wb_alu_result_q <= wb_alu_result_d;
      wb_regdst_q     <= wb_regdst_d;
      wb_reg_write_q  <= wb_reg_write_d;
      wb_mem_to_reg_q <= wb_mem_to_reg_d;
    end
  end

  assign wb_read_data  = wb_read_data_q;
  assign wb_alu_result = wb_alu_result_q;
  assign wb_regdst     = wb_regdst_q;
  assign wb_reg_write  = wb_reg_write_q;
  assign wb_mem_to_reg = wb_mem_to_reg_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] Address, Write_Data, dmem_rdata;
  logic [4:0]  regdst;
  logic        RegWrite_i, Mem_Read, Mem_Write, MemtoReg_i, dmem_ack;
  logic        stall, dmem_req, dmem_we, wb_reg_write, wb_mem_to_reg, bus_err;
  logic [31:0] dmem_addr, dmem_wdata, wb_read_data, wb_alu_result;
  logic [4:0]  wb_regdst;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        rw;
    logic        mtr;
    logic [31:0] rdata;
  } wb_exp_t;

  wb_exp_t exp_q[$];

  mem_wb_stage #(.DATA_W(32), .REG_W(5), .ACK_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .Address(Address), .Write_Data(Write_Data), .regdst(regdst),
    .RegWrite_i(RegWrite_i), .Mem_Read(Mem_Read), .Mem_Write(Mem_Write),
    .MemtoReg_i(MemtoReg_i),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .wb_read_data(wb_read_data), .wb_alu_result(wb_alu_result),
    .wb_regdst(wb_regdst), .wb_reg_write(wb_reg_write),
    .wb_mem_to_reg(wb_mem_to_reg), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run time limit reached");
    $fatal(1, "watchdog");
  end

  // Entered and left at a negedge. Drives one instruction, acks it after
  // ack_dly REQ cycles, then compares MEM/WB against the scoreboard.
  task automatic issue(input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [4:0] rd, input logic rw, input logic mr,
                       input logic mw, input logic mtr, input int ack_dly,
                       input logic [31:0] rdata);
    wb_exp_t e, got;
    logic memop;
    int stall_cnt;
    memop = mr | mw;
    Address = addr; Write_Data = wdata; regdst = rd;
    RegWrite_i = rw; Mem_Read = mr; Mem_Write = mw; MemtoReg_i = mtr;
    dmem_ack = 1'b0;
    e.alu = addr; e.rd = rd; e.rw = rw; e.mtr = mtr;
    e.rdata = (memop && !mw) ? rdata : 32'h0;
    exp_q.push_back(e);
    stall_cnt = 0;
    #1;
    total++;
    if (stall !== memop)
      $display("FAIL stall_idle: got %b want %b (addr %h)", stall, memop, addr);
    if (stall === 1'b1) stall_cnt++;
    if (stall !== memop) bad++;
    @(negedge clk);
    if (memop) begin
      for (int j = 0; j <= ack_dly; j++) begin
        total++;
        if (dmem_req !== 1'b1 || dmem_we !== mw || dmem_addr !== addr ||
            dmem_wdata !== wdata) begin
          bad++;
          $display("FAIL bus_req: req=%b we=%b addr=%h wdata=%h want 1 %b %h %h",
                   dmem_req, dmem_we, dmem_addr, dmem_wdata, mw, addr, wdata);
        end
        total++;
        if (wb_reg_write !== 1'b0 || wb_mem_to_reg !== 1'b0) begin
          bad++;
          $display("FAIL bubble: reg_write=%b mem_to_reg=%b want 0 0",
                   wb_reg_write, wb_mem_to_reg);
        end
        if (j == ack_dly) begin
          dmem_ack = 1'b1;
          dmem_rdata = rdata;
        end
        #1;
        total++;
        if (stall !== (j != ack_dly)) begin
          bad++;
          $display("FAIL stall_req: got %b want %b at req cycle %0d", stall,
                   (j != ack_dly), j);
        end
        if (stall === 1'b1) stall_cnt++;
        @(negedge clk);
        dmem_ack = 1'b0;
        dmem_rdata = 32'hBAD0_BAD0;
      end
      total++;
      if (stall_cnt != 1 + ack_dly) begin
        bad++;
        $display("FAIL stall_len: got %0d want %0d", stall_cnt, 1 + ack_dly);
      end
      total++;
      if (dmem_req !== 1'b0) begin
        bad++;
        $display("FAIL req_drop: dmem_req=%b want 0", dmem_req);
      end
    end
    got = '{alu: wb_alu_result, rd: wb_regdst, rw: wb_reg_write,
            mtr: wb_mem_to_reg, rdata: wb_read_data};
    if (exp_q.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard_empty: output with nothing expected");
    end else begin
      e = exp_q.pop_front();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL wb_out: got alu=%h rd=%0d rw=%b mtr=%b rdata=%h want alu=%h rd=%0d rw=%b mtr=%b rdata=%h",
                 got.alu, got.rd, got.rw, got.mtr, got.rdata,
                 e.alu, e.rd, e.rw, e.mtr, e.rdata);
      end
    end
  endtask

  task automatic idle_inputs();
    Address = 32'h0; Write_Data = 32'h0; regdst = 5'd0;
    RegWrite_i = 1'b0; Mem_Read = 1'b0; Mem_Write = 1'b0; MemtoReg_i = 1'b0;
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    total++;
    if (wb_read_data !== 32'h0 || wb_alu_result !== 32'h0 || wb_regdst !== 5'd0 ||
        wb_reg_write !== 1'b0 || wb_mem_to_reg !== 1'b0 || dmem_req !== 1'b0 ||
        dmem_we !== 1'b0 || bus_err !== 1'b0 || stall !== 1'b0) begin
      bad++;
      $display("FAIL reset: rd=%h alu=%h dst=%0d rw=%b mtr=%b req=%b we=%b err=%b stall=%b want all 0",
               wb_read_data, wb_alu_result, wb_regdst, wb_reg_write, wb_mem_to_reg,
               dmem_req, dmem_we, bus_err, stall);
    end
    rst = 1'b0;
  endtask

  task automatic test_alu();
    issue(32'h10, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 0, 32'h0);
    issue(32'hFFFF_FFFC, 32'h55, 5'd31, 1'b1, 1'b0, 1'b0, 1'b1, 0, 32'h0);
    issue(32'h1234_5678, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 32'h0);
  endtask

  task automatic test_load();
    issue(32'h10, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 0, 32'h0);
    issue(32'h40, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, 3, 32'hDEAD_BEEF);
  endtask

  task automatic test_store();
    issue(32'h80, 32'h1234, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 0, 32'hCAFE_F00D);
    issue(32'h84, 32'hA5A5, 5'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1, 32'h7777_7777);
  endtask

  task automatic test_back_to_back();
    issue(32'h0, 32'h0, 5'd1, 1'b1, 1'b1, 1'b0, 1'b1, 0, 32'h1111_1111);
    issue(32'h4, 32'h0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1, 2, 32'h2222_2222);
    issue(32'h20, 32'h0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 0, 32'h0);
  endtask

  task automatic test_reset_mid_access();
    Address = 32'h100; Write_Data = 32'h0; regdst = 5'd7;
    RegWrite_i = 1'b1; Mem_Read = 1'b1; Mem_Write = 1'b0; MemtoReg_i = 1'b1;
    dmem_ack = 1'b0;
    @(negedge clk);
    total++;
    if (dmem_req !== 1'b1) begin
      bad++;
      $display("FAIL rst_pre_req: dmem_req=%b want 1", dmem_req);
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (dmem_req !== 1'b0 || wb_reg_write !== 1'b0 || wb_mem_to_reg !== 1'b0 ||
        wb_alu_result !== 32'h0 || wb_regdst !== 5'd0 || wb_read_data !== 32'h0) begin
      bad++;
      $display("FAIL rst_mid_req: req=%b rw=%b mtr=%b alu=%h dst=%0d rd=%h want all 0",
               dmem_req, wb_reg_write, wb_mem_to_reg, wb_alu_result, wb_regdst,
               wb_read_data);
    end
    rst = 1'b0;
    Mem_Read = 1'b0; RegWrite_i = 1'b0; MemtoReg_i = 1'b0;
    Address = 32'h200; regdst = 5'd10;
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_0000;
    #1;
    total++;
    if (stall !== 1'b0) begin
      bad++;
      $display("FAIL late_ack_stall: stall=%b want 0", stall);
    end
    @(negedge clk);
    dmem_ack = 1'b0;
    total++;
    if (wb_read_data !== 32'h0 || wb_alu_result !== 32'h200 || dmem_req !== 1'b0) begin
      bad++;
      $display("FAIL late_ack: rd=%h alu=%h req=%b want 0 00000200 0",
               wb_read_data, wb_alu_result, dmem_req);
    end
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    Address = 32'h300; regdst = 5'd12; RegWrite_i = 1'b1;
    Mem_Read = 1'b1; Mem_Write = 1'b0; MemtoReg_i = 1'b1; dmem_ack = 1'b0;
    @(negedge clk);
    for (int j = 0; j < 4; j++) begin
      #1;
      total++;
      if (dmem_req !== 1'b1 || stall !== (j != 3)) begin
        bad++;
        $display("FAIL tmo_req: req=%b stall=%b want 1 %b at req cycle %0d",
                 dmem_req, stall, (j != 3), j);
      end
      @(negedge clk);
    end
    total++;
    if (dmem_req !== 1'b0 || bus_err !== 1'b1 || wb_reg_write !== 1'b0) begin
      bad++;
      $display("FAIL tmo_abort: req=%b err=%b rw=%b want 0 1 0",
               dmem_req, bus_err, wb_reg_write);
    end
    issue(32'h44, 32'h0, 5'd13, 1'b1, 1'b0, 1'b0, 1'b0, 0, 32'h0);
    total++;
    if (bus_err !== 1'b1) begin
      bad++;
      $display("FAIL tmo_sticky: bus_err=%b want 1", bus_err);
    end
  endtask
`else
  task automatic test_no_timeout();
    issue(32'h300, 32'h0, 5'd12, 1'b1, 1'b1, 1'b0, 1'b1, 20, 32'h0BAD_F00D);
    total++;
    if (bus_err !== 1'b0) begin
      bad++;
      $display("FAIL no_tmo_err: bus_err=%b want 0", bus_err);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_back_to_back();
    test_reset_mid_access();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
